hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the forwarding unit and sequences the pipeline registers: it stalls on load-use hazards, freezes EX for multi-cycle multiply/divide operations, and flushes IF/ID and ID/EX on taken branches. It also counts stall cycles for performance monitoring.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width
- MD_LATENCY, 4, cycles a mul/div op occupies EX; legal range 2..16

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rs1_IF_ID  in  REG_ADDR_W  source 1 of instruction in ID
- rs2_IF_ID  in  REG_ADDR_W  source 2 of instruction in ID
- uses_rs2_IF_ID  in  1  instruction in ID reads rs2
- rd_ID_EX  in  REG_ADDR_W  destination of instruction in EX
- MemRead_ID_EX  in  1  instruction in EX is a load
- md_op_ID_EX  in  1  instruction in EX is a multi-cycle mul/div
- branch_taken_EX  in  1  branch in EX resolved taken
- PCWrite  out  1  PC load enable
- IF_ID_Write  out  1  IF/ID register enable
- ID_EX_Write  out  1  ID/EX register enable
- IF_ID_Flush  out  1  zero IF/ID on next edge
- ID_EX_Flush  out  1  load bubble into ID/EX on next edge
- EX_MEM_Bubble  out  1  load bubble into EX/MEM on next edge
- md_busy  out  1  FSM in MD_WAIT
- stall_cycles  out  16  saturating count of cycles with PCWrite=0

## Operation
- FSM states: RUN, MD_WAIT. Down-counter md_cnt, 4 bits.
- lu_hazard = MemRead_ID_EX & (rd_ID_EX != 0) & ((rd_ID_EX == rs1_IF_ID) | (uses_rs2_IF_ID & rd_ID_EX == rs2_IF_ID)).
- Default outputs (RUN, no event): PCWrite=1, IF_ID_Write=1, ID_EX_Write=1, all flush/bubble=0.
- Priority in RUN, highest first:
  - branch_taken_EX: IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1 (loads target); lu_hazard ignored.
  - md_op_ID_EX: PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1; next state MD_WAIT, md_cnt <= MD_LATENCY-2.
  - lu_hazard: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
- MD_WAIT:
  - md_cnt != 0: same freeze as md entry; md_cnt decrements.
  - md_cnt == 0: final EX cycle, default outputs (EX/MEM captures result, ID/EX advances); next state RUN.
  - branch_taken_EX, md_op_ID_EX and lu_hazard are ignored (EX holds the mul/div op).
- Total freeze for one mul/div = MD_LATENCY-1 cycles; the op spends MD_LATENCY cycles in EX.
- Back-to-back mul/div: after returning to RUN, the next md_op_ID_EX re-enters MD_WAIT with no idle gap.
- stall_cycles increments each cycle PCWrite=0 and saturates at 16'hFFFF.
- md_busy = (state == MD_WAIT).

## Timing
- Reset (rst_n=0, asynchronous): state=RUN, md_cnt=0, stall_cycles=0. While rst_n=0, PCWrite, IF_ID_Write and ID_EX_Write are 0; flushes, EX_MEM_Bubble and md_busy are 0.
- First edge after deassertion operates normally.
- All control outputs are combinational from state, md_cnt and current-cycle inputs, so they take effect at the next rising edge. State, md_cnt and stall_cycles are registered.
- Load-use adds exactly 1 bubble. The following cycle the load is in MEM, lu_hazard clears, and the forwarding unit supplies the data.
- Reset asserted during MD_WAIT aborts the op immediately: state=RUN, md_cnt=0.
- stall_cycles update is visible the cycle after the stall cycle.

## Test plan
- Reset: hold rst_n=0 with random inputs -> PCWrite=0, all flushes 0, md_busy=0, stall_cycles=0. Release -> defaults PCWrite=1, IF_ID_Write=1, ID_EX_Write=1.
- Load-use: MemRead_ID_EX=1, rd_ID_EX=5, rs1_IF_ID=5 for 1 cycle -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 for that cycle only; stall_cycles=1. Repeat with rd_ID_EX=0, and with rs2 match while uses_rs2_IF_ID=0 -> no stall.
- Branch vs load-use: branch_taken_EX=1 with lu_hazard true -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1; stall_cycles unchanged.
- Mul/div, MD_LATENCY=4: md_op_ID_EX=1 for 1 cycle -> 3 freeze cycles (PCWrite=0, EX_MEM_Bubble=1), md_busy=1 on freeze cycles 2-3, defaults on cycle 4; stall_cycles=3. Then a back-to-back md op -> stall_cycles=6.
- Reset mid-op: assert rst_n=0 on the second freeze cycle -> md_busy=0 immediately. After release, the FSM is in RUN with no residual stall.
- Saturation: force 70000 load-use stall cycles -> stall_cycles=16'hFFFF and holds.

Source files
------------

// File: rtl/hazard_stall_if.sv
// Hazard controller bus: operand/destination info in, pipeline enables out.
// master = pipeline side, slave = hazard_stall_ctrl.
interface hazard_stall_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] rs1_IF_ID;
  logic [REG_ADDR_W-1:0] rs2_IF_ID;
  logic                  uses_rs2_IF_ID;
  logic [REG_ADDR_W-1:0] rd_ID_EX;
  logic                  MemRead_ID_EX;
  logic                  md_op_ID_EX;
  logic                  branch_taken_EX;
  logic                  PCWrite;
  logic                  IF_ID_Write;
  logic                  ID_EX_Write;
  logic                  IF_ID_Flush;
  logic                  ID_EX_Flush;
  logic                  EX_MEM_Bubble;
  logic                  md_busy;
  logic [15:0]           stall_cycles;

  modport master (
    output rs1_IF_ID, rs2_IF_ID, uses_rs2_IF_ID,
    output rd_ID_EX, MemRead_ID_EX, md_op_ID_EX,
    output branch_taken_EX,
    input  PCWrite, IF_ID_Write, ID_EX_Write,
    input  IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble,
    input  md_busy, stall_cycles
  );

  modport slave (
    input  rs1_IF_ID, rs2_IF_ID, uses_rs2_IF_ID,
    input  rd_ID_EX, MemRead_ID_EX, md_op_ID_EX,
    input  branch_taken_EX,
    output PCWrite, IF_ID_Write, ID_EX_Write,
    output IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble,
    output md_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall, mul/div EX freeze and branch flush sequencer.
// Ports: clk, rst_n (async low), hz (hazard_stall_if.slave).
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  hazard_stall_if.slave   hz
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t      state, state_n;
  logic [3:0]  md_cnt, md_cnt_n;
  logic [15:0] stall_q;

  logic lu_hazard;
  logic br, md;
  logic pc_w, ifid_w, idex_w;
  logic ifid_fl, idex_fl, bub;

  assign br = hz.branch_taken_EX;
  assign md = hz.md_op_ID_EX;

  assign lu_hazard = hz.MemRead_ID_EX
    & (hz.rd_ID_EX != '0)
    & ((hz.rd_ID_EX == hz.rs1_IF_ID)
      | (hz.uses_rs2_IF_ID
         & (hz.rd_ID_EX == hz.rs2_IF_ID)));

  always_comb begin
    pc_w     = 1'b1;
    ifid_w   = 1'b1;
    idex_w   = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    bub      = 1'b0;
    state_n  = state;
    md_cnt_n = md_cnt;
    unique case (state)
      RUN: begin
        unique case (1'b1)
          br: begin
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
          end
          (!br && md): begin
            pc_w     = 1'b0;
            ifid_w   = 1'b0;
            idex_w   = 1'b0;
            bub      = 1'b1;
            state_n  = MD_WAIT;
            md_cnt_n = 4'(MD_LATENCY - 2);
          end
          (!br && !md && lu_hazard): begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_fl = 1'b1;
          end
          default: ;
        endcase
      end
      MD_WAIT: begin
        if (md_cnt != 4'd0) begin
          pc_w     = 1'b0;
          ifid_w   = 1'b0;
          idex_w   = 1'b0;
          bub      = 1'b1;
          md_cnt_n = md_cnt - 4'd1;
        end else begin
          // last EX cycle: result goes to EX/MEM
          state_n = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      md_cnt  <= 4'd0;
      stall_q <= 16'd0;
    end else begin
      state  <= state_n;
      md_cnt <= md_cnt_n;
      if (!pc_w && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  // enables held low while in reset
  assign hz.PCWrite       = rst_n & pc_w;
  assign hz.IF_ID_Write   = rst_n & ifid_w;
  assign hz.ID_EX_Write   = rst_n & idex_w;
  assign hz.IF_ID_Flush   = rst_n & ifid_fl;
  assign hz.ID_EX_Flush   = rst_n & idex_fl;
  assign hz.EX_MEM_Bubble = rst_n & bub;
  assign hz.md_busy       = rst_n & (state == MD_WAIT);
  assign hz.stall_cycles  = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with a queue scoreboard.
// Stimulus pushes expected outputs; monitor pops at each negedge.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  hazard_stall_if #(.REG_ADDR_W(5)) hz ();

  hazard_stall_ctrl #(
    .REG_ADDR_W(5),
    .MD_LATENCY(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  typedef struct {
    string      name;
    logic [6:0] ctl;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  bit done = 0;

  // ctl = {PCWrite,IF_ID_Write,ID_EX_Write,
  //        IF_ID_Flush,ID_EX_Flush,EX_MEM_Bubble,md_busy}
  localparam logic [6:0] C_RST  = 7'b000_0000;
  localparam logic [6:0] C_IDLE = 7'b111_0000;
  localparam logic [6:0] C_LU   = 7'b001_0100;
  localparam logic [6:0] C_BR   = 7'b111_1100;
  localparam logic [6:0] C_MD0  = 7'b000_0010;
  localparam logic [6:0] C_MDW  = 7'b000_0011;
  localparam logic [6:0] C_MDL  = 7'b111_0001;

  task automatic drive(
    input logic r, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic u2,
    input logic [4:0] rd, input logic mr,
    input logic mdop, input logic bt);
    rst_n = r;
    hz.rs1_IF_ID = rs1;
    hz.rs2_IF_ID = rs2;
    hz.uses_rs2_IF_ID = u2;
    hz.rd_ID_EX = rd;
    hz.MemRead_ID_EX = mr;
    hz.md_op_ID_EX = mdop;
    hz.branch_taken_EX = bt;
  endtask

  task automatic step(
    input string nm, input logic r,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic u2, input logic [4:0] rd,
    input logic mr, input logic mdop,
    input logic bt, input logic [6:0] c,
    input logic [15:0] sc);
    exp_t e;
    @(posedge clk);
    #1;
    drive(r, rs1, rs2, u2, rd, mr, mdop, bt);
    e.name = nm;
    e.ctl = c;
    e.sc = sc;
    q.push_back(e);
  endtask

  task automatic idle(input string nm,
    input logic [15:0] sc);
    step(nm, 1, 0, 0, 0, 0, 0, 0, 0, C_IDLE, sc);
  endtask

  initial begin : monitor
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        act = {hz.PCWrite, hz.IF_ID_Write,
               hz.ID_EX_Write, hz.IF_ID_Flush,
               hz.ID_EX_Flush, hz.EX_MEM_Bubble,
               hz.md_busy};
        n_chk++;
        if (act !== e.ctl || hz.stall_cycles !== e.sc) begin
          n_fail++;
          if (n_fail <= 20)
            $display("FAIL %s: ctl=%b sc=%0d expected ctl=%b sc=%0d",
              e.name, act, hz.stall_cycles, e.ctl, e.sc);
        end
      end
    end
  end

  initial begin : stim
    int wait_cyc;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // reset with random inputs
    for (int i = 0; i < 3; i++)
      step("reset", 0, 5'($urandom), 5'($urandom),
        1'($urandom), 5'($urandom), 1'($urandom),
        1'($urandom), 1'($urandom), C_RST, 16'd0);
    idle("release", 0);
    // load-use on rs1
    step("lu_rs1", 1, 5, 0, 0, 5, 1, 0, 0, C_LU, 0);
    idle("lu_after", 1);
    // rd = 0 never stalls
    step("lu_rd0", 1, 0, 0, 0, 0, 1, 0, 0, C_IDLE, 1);
    // rs2 match ignored when rs2 unused
    step("lu_rs2_unused", 1, 3, 7, 0, 7, 1, 0, 0, C_IDLE, 1);
    step("lu_rs2_used", 1, 3, 7, 1, 7, 1, 0, 0, C_LU, 1);
    idle("lu_rs2_after", 2);
    // branch beats load-use and md
    step("br_lu", 1, 5, 0, 0, 5, 1, 0, 1, C_BR, 2);
    step("br_md", 1, 0, 0, 0, 0, 0, 1, 1, C_BR, 2);
    idle("br_after", 2);
    // mul/div, latency 4: 3 freeze cycles
    step("md_entry", 1, 0, 0, 0, 0, 0, 1, 0, C_MD0, 2);
    step("md_wait1", 1, 5, 0, 0, 5, 1, 1, 1, C_MDW, 3);
    step("md_wait2", 1, 0, 0, 0, 0, 0, 1, 0, C_MDW, 4);
    step("md_last", 1, 0, 0, 0, 0, 0, 1, 0, C_MDL, 5);
    // back-to-back op
    step("md2_entry", 1, 0, 0, 0, 0, 0, 1, 0, C_MD0, 5);
    step("md2_wait1", 1, 0, 0, 0, 0, 0, 1, 0, C_MDW, 6);
    step("md2_wait2", 1, 0, 0, 0, 0, 0, 1, 0, C_MDW, 7);
    step("md2_last", 1, 0, 0, 0, 0, 0, 0, 0, C_MDL, 8);
    idle("md2_after", 8);
    // reset mid-op
    step("md3_entry", 1, 0, 0, 0, 0, 0, 1, 0, C_MD0, 8);
    step("md3_rst", 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 0);
    step("md3_rst_hold", 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 0);
    idle("md3_release", 0);
    idle("md3_run", 0);
    // saturation
    for (int i = 0; i < 70000; i++)
      step("sat", 1, 9, 0, 0, 9, 1, 0, 0, C_LU,
        (i > 65535) ? 16'hFFFF : 16'(i));
    idle("sat_hold1", 16'hFFFF);
    idle("sat_hold2", 16'hFFFF);
    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 100) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
